mem_access_stage: RTL and testbench

//  MEM-stage data-memory access unit between EX/MEM and MEM/WB pipeline registers.

---
 rtl/mem_access_stage.sv | 201 ++++++++++++++++++++
 tb/tb_mem_access_stage.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// MEM-stage data-memory access unit: request/ready port, byte enables, load align/extend.
// Optional macro MEM_MISALIGN_TRAP_EN traps misaligned half/word accesses instead of aligning.
module mem_access_stage #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        startin,
  input  logic        MEM_mem_read,
  input  logic        MEM_mem_write,
  input  logic [1:0]  MEM_size,
  input  logic        MEM_load_unsigned,
  input  logic [31:0] MEM_alu_result,
  input  logic [31:0] MEM_write_data,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ready,
  output logic [31:0] MEM_mem_data,
  output logic        mem_stall,
  output logic        mem_error,
  output logic        mem_misalign
);

  // state  | meaning
  // IDLE   | no access outstanding; waits for a load/store in MEM
  // ACCESS | request on the port, waiting for dmem_ready or timeout
  // DONE   | result presented, pipeline released for one cycle
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  state_t            state_q, state_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       data_q, data_d;
  logic              err_q, err_d;
  logic              mis_q, mis_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        ld_size_q, ld_size_d;
  logic [1:0]        ld_off_q, ld_off_d;
  logic              ld_uns_q, ld_uns_d;

  logic              op;
  logic              trap_hit;
  logic [3:0]        be_new;
  logic [31:0]       wdata_new;
  logic [31:0]       load_data;
  logic [7:0]        lane8;
  logic [15:0]       lane16;

  assign op = MEM_mem_read | MEM_mem_write;

`ifdef MEM_MISALIGN_TRAP_EN
  assign trap_hit = ((MEM_size == 2'b01) && MEM_alu_result[0]) ||
                    (MEM_size[1] && (MEM_alu_result[1:0] != 2'b00));
`else
  assign trap_hit = 1'b0;
`endif

  always_comb begin
    be_new    = 4'b1111;
    wdata_new = MEM_write_data;
    case (MEM_size)
      2'b00: begin
        be_new    = 4'b0001 << MEM_alu_result[1:0];
        wdata_new = {4{MEM_write_data[7:0]}};
      end
      2'b01: begin
        be_new    = MEM_alu_result[1] ? 4'b1100 : 4'b0011;
        wdata_new = {2{MEM_write_data[15:0]}};
      end
      default: ;
    endcase
  end

  // Lane selection uses the offset/size captured at request time.
  always_comb begin
    case (ld_off_q)
      2'd0:    lane8 = dmem_rdata[7:0];
      2'd1:    lane8 = dmem_rdata[15:8];
      2'd2:    lane8 = dmem_rdata[23:16];
      default: lane8 = dmem_rdata[31:24];
    endcase
    lane16 = ld_off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (ld_size_q)
      2'b00:   load_data = {{24{~ld_uns_q & lane8[7]}}, lane8};
      2'b01:   load_data = {{16{~ld_uns_q & lane16[15]}}, lane16};
      default: load_data = dmem_rdata;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    data_d    = data_q;
    err_d     = 1'b0;
    mis_d     = 1'b0;
    cnt_d     = cnt_q;
    ld_size_d = ld_size_q;
    ld_off_d  = ld_off_q;
    ld_uns_d  = ld_uns_q;
    case (state_q)
      IDLE: begin
        req_d = 1'b0;
        if (op && trap_hit) begin
          state_d = DONE;
          data_d  = 32'h0;
          mis_d   = 1'b1;
        end else if (op) begin
          state_d   = ACCESS;
          req_d     = 1'b1;
          we_d      = MEM_mem_write;
          addr_d    = {MEM_alu_result[31:2], 2'b00};
          wdata_d   = wdata_new;
          be_d      = be_new;
          cnt_d     = '0;
          ld_size_d = MEM_size;
          ld_off_d  = MEM_alu_result[1:0];
          ld_uns_d  = MEM_load_unsigned;
        end
      end
      ACCESS: begin
        if (dmem_ready) begin
          state_d = DONE;
          req_d   = 1'b0;
          we_d    = 1'b0;
          be_d    = 4'b0000;
          if (!we_q) data_d = load_data;
        end else if ((TIMEOUT_CYCLES > 0) && (cnt_q == CNT_LAST)) begin
          state_d = DONE;
          req_d   = 1'b0;
          we_d    = 1'b0;
          be_d    = 4'b0000;
          data_d  = 32'h0;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge startin) begin
    if (startin) begin
      state_q   <= IDLE;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= 32'h0;
      wdata_q   <= 32'h0;
      be_q      <= 4'b0000;
      data_q    <= 32'h0;
      err_q     <= 1'b0;
      mis_q     <= 1'b0;
      cnt_q     <= '0;
      ld_size_q <= 2'b00;
      ld_off_q  <= 2'b00;
      ld_uns_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      be_q      <= be_d;
      data_q    <= data_d;
      err_q     <= err_d;
      mis_q     <= mis_d;
      cnt_q     <= cnt_d;
      ld_size_q <= ld_size_d;
      ld_off_q  <= ld_off_d;
      ld_uns_q  <= ld_uns_d;
    end
  end

  assign dmem_req     = req_q;
  assign dmem_we      = we_q;
  assign dmem_addr    = addr_q;
  assign dmem_wdata   = wdata_q;
  assign dmem_be      = be_q;
  assign MEM_mem_data = data_q;
  assign mem_error    = err_q;
  assign mem_misalign = mis_q;
  assign mem_stall    = ((state_q == IDLE) && op) || (state_q == ACCESS);

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: driver pushes expected request/result records,
// a negedge monitor pops and compares them when the DUT issues a request or releases the stall.
module tb_mem_access_stage;

  logic        clk;
  logic        startin;
  logic        MEM_mem_read;
  logic        MEM_mem_write;
  logic [1:0]  MEM_size;
  logic        MEM_load_unsigned;
  logic [31:0] MEM_alu_result;
  logic [31:0] MEM_write_data;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_rdata;
  logic        dmem_ready;
  logic [31:0] MEM_mem_data;
  logic        mem_stall;
  logic        mem_error;
  logic        mem_misalign;

  mem_access_stage #(.TIMEOUT_CYCLES(16)) dut (
    .clk               (clk),
    .startin           (startin),
    .MEM_mem_read      (MEM_mem_read),
    .MEM_mem_write     (MEM_mem_write),
    .MEM_size          (MEM_size),
    .MEM_load_unsigned (MEM_load_unsigned),
    .MEM_alu_result    (MEM_alu_result),
    .MEM_write_data    (MEM_write_data),
    .dmem_req          (dmem_req),
    .dmem_we           (dmem_we),
    .dmem_addr         (dmem_addr),
    .dmem_wdata        (dmem_wdata),
    .dmem_be           (dmem_be),
    .dmem_rdata        (dmem_rdata),
    .dmem_ready        (dmem_ready),
    .MEM_mem_data      (MEM_mem_data),
    .mem_stall         (mem_stall),
    .mem_error         (mem_error),
    .mem_misalign      (mem_misalign)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    string       name;
  } req_t;

  typedef struct {
    logic [31:0] data;
    logic        err;
    logic        mis;
    string       name;
  } rsp_t;

  req_t req_q[$];
  rsp_t rsp_q[$];

  int          n_checks = 0;
  int          n_errors = 0;
  int          resp_delay = 0;
  bit          resp_never = 0;
  logic [31:0] resp_rdata = 32'h0;

  task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory responder: asserts ready after resp_delay wait cycles of an active request.
  initial begin
    int wait_cnt;
    wait_cnt   = 0;
    dmem_ready = 1'b0;
    dmem_rdata = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      if (dmem_req && !startin) begin
        if (!resp_never && wait_cnt == resp_delay) begin
          dmem_ready = 1'b1;
          dmem_rdata = resp_rdata;
          wait_cnt   = 0;
        end else begin
          dmem_ready = 1'b0;
          wait_cnt++;
        end
      end else begin
        dmem_ready = 1'b0;
        wait_cnt   = 0;
      end
    end
  end

  // Monitor: request issue and stall release each pop one expected record.
  initial begin
    logic prev_stall, prev_req;
    req_t er;
    rsp_t es;
    prev_stall = 1'b0;
    prev_req   = 1'b0;
    forever begin
      @(negedge clk);
      if (startin) begin
        prev_stall = 1'b0;
        prev_req   = 1'b0;
      end else begin
        if (dmem_req && !prev_req) begin
          if (req_q.size() == 0) begin
            check(1'b0, "unexpected_req", dmem_addr, 32'h0);
          end else begin
            er = req_q.pop_front();
            check(dmem_we == er.we, {er.name, "_we"}, {31'h0, dmem_we}, {31'h0, er.we});
            check(dmem_addr == er.addr, {er.name, "_addr"}, dmem_addr, er.addr);
            check(dmem_wdata == er.wdata, {er.name, "_wdata"}, dmem_wdata, er.wdata);
            check(dmem_be == er.be, {er.name, "_be"}, {28'h0, dmem_be}, {28'h0, er.be});
          end
        end
        if (prev_stall && !mem_stall) begin
          if (rsp_q.size() == 0) begin
            check(1'b0, "unexpected_done", MEM_mem_data, 32'h0);
          end else begin
            es = rsp_q.pop_front();
            check(MEM_mem_data == es.data, {es.name, "_data"}, MEM_mem_data, es.data);
            check(mem_error == es.err, {es.name, "_error"}, {31'h0, mem_error}, {31'h0, es.err});
            check(mem_misalign == es.mis, {es.name, "_misalign"}, {31'h0, mem_misalign}, {31'h0, es.mis});
          end
        end else begin
          check(!mem_error && !mem_misalign, "stray_pulse", {30'h0, mem_error, mem_misalign}, 32'h0);
        end
        prev_stall = mem_stall;
        prev_req   = dmem_req;
      end
    end
  end

  task automatic run_op(
    input string       name,
    input logic        rd,
    input logic        wr,
    input logic [1:0]  size,
    input logic        uns,
    input logic [31:0] addr,
    input logic [31:0] wd,
    input logic [31:0] rdata,
    input int          delay,
    input bit          never,
    input bit          exp_req,
    input logic [31:0] exp_addr,
    input logic [31:0] exp_wdata,
    input logic [3:0]  exp_be,
    input logic [31:0] exp_data,
    input logic        exp_err,
    input logic        exp_mis,
    input int          exp_stall
  );
    req_t r;
    rsp_t s;
    int   stall_cnt;
    bit   done;
    @(posedge clk);
    #2;
    resp_delay = delay;
    resp_never = never;
    resp_rdata = rdata;
    if (exp_req) begin
      r.we = wr; r.addr = exp_addr; r.wdata = exp_wdata; r.be = exp_be; r.name = name;
      req_q.push_back(r);
    end
    s.data = exp_data; s.err = exp_err; s.mis = exp_mis; s.name = name;
    rsp_q.push_back(s);
    MEM_mem_read      = rd;
    MEM_mem_write     = wr;
    MEM_size          = size;
    MEM_load_unsigned = uns;
    MEM_alu_result    = addr;
    MEM_write_data    = wd;
    #1;
    stall_cnt = 0;
    done      = 1'b0;
    for (int i = 0; i < 64 && !done; i++) begin
      if (mem_stall) stall_cnt++;
      else done = 1'b1;
      if (!done) begin
        @(posedge clk);
        #2;
      end
    end
    MEM_mem_read  = 1'b0;
    MEM_mem_write = 1'b0;
    check(done, {name, "_finished"}, {31'h0, done}, 32'h1);
    check(stall_cnt == exp_stall, {name, "_stall_cycles"}, stall_cnt, exp_stall);
  endtask

  task automatic check_all_zero(input string name);
    check(dmem_req == 1'b0, {name, "_req"}, {31'h0, dmem_req}, 32'h0);
    check(dmem_we == 1'b0, {name, "_we"}, {31'h0, dmem_we}, 32'h0);
    check(dmem_addr == 32'h0, {name, "_addr"}, dmem_addr, 32'h0);
    check(dmem_wdata == 32'h0, {name, "_wdata"}, dmem_wdata, 32'h0);
    check(dmem_be == 4'h0, {name, "_be"}, {28'h0, dmem_be}, 32'h0);
    check(MEM_mem_data == 32'h0, {name, "_data"}, MEM_mem_data, 32'h0);
    check(mem_stall == 1'b0, {name, "_stall"}, {31'h0, mem_stall}, 32'h0);
    check(mem_error == 1'b0, {name, "_error"}, {31'h0, mem_error}, 32'h0);
    check(mem_misalign == 1'b0, {name, "_misalign"}, {31'h0, mem_misalign}, 32'h0);
  endtask

  initial begin
    req_t r;
    startin           = 1'b1;
    MEM_mem_read      = 1'b0;
    MEM_mem_write     = 1'b0;
    MEM_size          = 2'b00;
    MEM_load_unsigned = 1'b0;
    MEM_alu_result    = 32'h0;
    MEM_write_data    = 32'h0;
    #12;
    check_all_zero("reset");
    @(posedge clk);
    #2;
    startin = 1'b0;

    //      name        rd wr size  uns addr        wdata       rdata       dly nev req eaddr       ewdata      ebe     edata       err mis stall
    run_op("ld_word",   1, 0, 2'b10, 0, 32'h104, 32'h0,       32'hDEADBEEF, 0, 0, 1, 32'h104, 32'h0,       4'b1111, 32'hDEADBEEF, 0, 0, 2);
    run_op("ld_byte_s", 1, 0, 2'b00, 0, 32'h203, 32'h0,       32'h80123456, 1, 0, 1, 32'h200, 32'h0,       4'b1000, 32'hFFFFFF80, 0, 0, 3);
    run_op("ld_byte_u", 1, 0, 2'b00, 1, 32'h203, 32'h0,       32'h80123456, 0, 0, 1, 32'h200, 32'h0,       4'b1000, 32'h00000080, 0, 0, 2);
    run_op("st_half",   0, 1, 2'b01, 0, 32'h302, 32'h0000ABCD, 32'h0,       0, 0, 1, 32'h300, 32'hABCDABCD, 4'b1100, 32'h00000080, 0, 0, 2);
    run_op("st_byte",   0, 1, 2'b00, 0, 32'h101, 32'h1234565A, 32'h0,       0, 0, 1, 32'h100, 32'h5A5A5A5A, 4'b0010, 32'h00000080, 0, 0, 2);
    run_op("ld_half_s", 1, 0, 2'b01, 0, 32'h302, 32'h0,       32'h80011234, 2, 0, 1, 32'h300, 32'h0,       4'b1100, 32'hFFFF8001, 0, 0, 4);
    run_op("ld_half_u", 1, 0, 2'b01, 1, 32'h300, 32'h0,       32'h1234F00D, 0, 0, 1, 32'h300, 32'h0,       4'b0011, 32'h0000F00D, 0, 0, 2);
    run_op("rd_wr_st",  1, 1, 2'b10, 0, 32'h400, 32'hCAFEF00D, 32'h0,       0, 0, 1, 32'h400, 32'hCAFEF00D, 4'b1111, 32'h0000F00D, 0, 0, 2);
    run_op("timeout",   1, 0, 2'b10, 0, 32'h500, 32'h0,       32'h0,        0, 1, 1, 32'h500, 32'h0,       4'b1111, 32'h00000000, 1, 0, 17);
    run_op("ld_byte_0", 1, 0, 2'b00, 1, 32'h200, 32'h0,       32'h000000FF, 0, 0, 1, 32'h200, 32'h0,       4'b0001, 32'h000000FF, 0, 0, 2);
    run_op("ld_size11", 1, 0, 2'b11, 0, 32'h108, 32'h0,       32'h11223344, 1, 0, 1, 32'h108, 32'h0,       4'b1111, 32'h11223344, 0, 0, 3);
    run_op("st_byte_3", 0, 1, 2'b00, 0, 32'h103, 32'h000000C3, 32'h0,       0, 0, 1, 32'h100, 32'hC3C3C3C3, 4'b1000, 32'h11223344, 0, 0, 2);
`ifdef MEM_MISALIGN_TRAP_EN
    run_op("misalign",  1, 0, 2'b10, 0, 32'h101, 32'h0,       32'h55667788, 0, 0, 0, 32'h0,   32'h0,       4'b0000, 32'h00000000, 0, 1, 1);
`else
    run_op("misalign",  1, 0, 2'b10, 0, 32'h101, 32'h0,       32'h55667788, 0, 0, 1, 32'h100, 32'h0,       4'b1111, 32'h55667788, 0, 0, 2);
`endif

    // Reset pulsed while a load is stuck in ACCESS.
    @(posedge clk);
    #2;
    resp_never = 1'b1;
    r.we = 1'b0; r.addr = 32'h600; r.wdata = 32'h0; r.be = 4'b1111; r.name = "rst_mid";
    req_q.push_back(r);
    MEM_mem_read      = 1'b1;
    MEM_size          = 2'b10;
    MEM_load_unsigned = 1'b0;
    MEM_alu_result    = 32'h600;
    MEM_write_data    = 32'h0;
    repeat (3) @(posedge clk);
    #2;
    check(dmem_req == 1'b1, "rst_mid_pre_req", {31'h0, dmem_req}, 32'h1);
    startin       = 1'b1;
    MEM_mem_read  = 1'b0;
    #1;
    check_all_zero("rst_mid");
    @(negedge clk);
    @(posedge clk);
    #2;
    startin    = 1'b0;
    resp_never = 1'b0;

    run_op("post_rst",  1, 0, 2'b10, 0, 32'h10C, 32'h0,       32'h0BADF00D, 0, 0, 1, 32'h10C, 32'h0,       4'b1111, 32'h0BADF00D, 0, 0, 2);

    repeat (3) @(posedge clk);
    check(req_q.size() == 0, "req_queue_drained", req_q.size(), 32'h0);
    check(rsp_q.size() == 0, "rsp_queue_drained", rsp_q.size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1, "bench time limit reached");
  end

endmodule
